// File: rtl/mult_share_pkg.sv
// Shared types and the round-robin pick used by the multiplier-sharing arbiter.
// rr_pick scans a fixed-width request vector so any requester count up to RR_MAX fits.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } ms_state_t;

  localparam int unsigned RR_MAX = 64;
  localparam int unsigned RR_IW  = $clog2(RR_MAX);

  // First set bit of valid at or after ptr, wrapping at nreq; 0 when nothing is set.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned       ptr,
                                          input int unsigned       nreq);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (i < nreq) && valid[idx[RR_IW-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/NxN_multiplier.sv
// Purely combinational unsigned N x N multiplier producing the full 2N-bit product.
// No state, no handshake: the product follows the operands in the same cycle.
module NxN_multiplier #(
  parameter int N = 4
) (
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product
);

  localparam int PW = 2 * N;

  assign product = PW'(multiplicand) * PW'(multiplier);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin shares one combinational multiplier among R requesters; result two cycles after accept.
// While a response is held (rsp_ready low) no new request is accepted and req_ready stays zero.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int R   = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [R-1:0]        req_valid,
  input  logic [R-1:0][N-1:0] req_a,
  input  logic [R-1:0][N-1:0] req_b,
  output logic [R-1:0]        req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*N-1:0]      rsp_product,
  output logic [IDW-1:0]      rsp_id
);

  ms_state_t        state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N-1:0]     op_a_q, op_a_d;
  logic [N-1:0]     op_b_q, op_b_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic [2*N-1:0]   product;
  logic [IDW-1:0]   gnt;
  logic             any_vld;
  logic             accept;

  assign any_vld = |req_valid;
  assign gnt     = IDW'(rr_pick(RR_MAX'(req_valid), 32'(rr_ptr_q), 32'(R)));

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && any_vld) req_ready[gnt] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  // Operands come only from the captured registers, so requesters may change inputs after accept.
  NxN_multiplier #(
    .N(N)
  ) u_mult (
    .multiplicand(op_a_q),
    .multiplier  (op_b_q),
    .product     (product)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CALC;
          op_a_d   = req_a[gnt];
          op_b_d   = req_b[gnt];
          id_d     = gnt;
          rr_ptr_d = (gnt == IDW'(R - 1)) ? '0 : gnt + IDW'(1);
        end
      end
      CALC: begin
        state_d = RESP;
        prod_d  = product;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_product = prod_q;
  assign rsp_id      = id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a transaction-level reference model checked every cycle.
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [R-1:0]        req_valid;
  logic [R-1:0][N-1:0] req_a;
  logic [R-1:0][N-1:0] req_b;
  logic [R-1:0]        req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2*N-1:0]      rsp_product;
  logic [IDW-1:0]      rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  int glog[$];
  int rid_log[$];
  int rp_log[$];

  // Reference model: one outstanding job, its result known at accept time.
  bit m_busy = 1'b0;
  bit m_calc_done = 1'b0;
  int m_ptr = 0;
  int m_id = 0;
  int m_prod = 0;

  mult_share_arbiter #(.N(N), .R(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_product(rsp_product),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [R-1:0] v, input int p);
    for (int k = 0; k < R; k++) begin
      if (v[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_busy = 1'b0; m_calc_done = 1'b0; m_ptr = 0; m_id = 0; m_prod = 0;
    end else if (!m_busy) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_prod = int'(req_a[g]) * int'(req_b[g]);
        m_id = g;
        m_ptr = (g + 1) % R;
        m_busy = 1'b1;
        m_calc_done = 1'b0;
      end
    end else if (!m_calc_done) begin
      m_calc_done = 1'b1;
    end else if (rsp_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    int g;
    int er;
    g = pick(req_valid, m_ptr);
    er = (!m_busy && g >= 0) ? (1 << g) : 0;
    chk("model req_ready", int'(req_ready), er);
    chk("model rsp_valid", int'(rsp_valid), int'(m_busy && m_calc_done));
    if (m_busy && m_calc_done) begin
      chk("model rsp_product", int'(rsp_product), m_prod);
      chk("model rsp_id", int'(rsp_id), m_id);
    end
    if (!rst_n) begin
      chk("reset rsp_product", int'(rsp_product), 0);
      chk("reset rsp_id", int'(rsp_id), 0);
    end
  end

  // Observed grants and completed responses, for the directed order checks.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < R; k++) if (req_ready[k]) glog.push_back(k);
      if (rsp_valid && rsp_ready) begin
        rid_log.push_back(int'(rsp_id));
        rp_log.push_back(int'(rsp_product));
      end
    end
  end

  task automatic clear_logs();
    glog.delete();
    rid_log.delete();
    rp_log.delete();
  endtask

  task automatic chk_q(input string name, input int q[$], input int n,
                       input int e0, input int e1 = 0, input int e2 = 0, input int e3 = 0);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, " count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++) chk(name, q[i], e[i]);
  endtask

  task automatic run_mask(input logic [R-1:0] mask, input int nrsp);
    int got;
    logic [R-1:0] g;
    got = 0;
    req_valid = mask;
    for (int c = 0; c < 60 && (req_valid != 0 || got < nrsp); c++) begin
      @(negedge clk);
      g = req_ready;
      if (rsp_valid && rsp_ready) got++;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
    end
    chk("run_mask completed", int'(req_valid == 0 && got == nrsp), 1);
    req_valid = '0;
  endtask

  task automatic wait_grant(input int id);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = req_ready[id];
      @(posedge clk); #1;
    end
    chk("grant within bound", int'(ok), 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int p, output int id);
    bit ok;
    ok = 1'b0;
    p = -1;
    id = -1;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1;
        p = int'(rsp_product);
        id = int'(rsp_id);
      end
      @(posedge clk); #1;
    end
    chk("response within bound", int'(ok), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int id;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset req_ready", int'(req_ready), 0);
    chk("reset rsp_valid", int'(rsp_valid), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // All four from reset: grants 0..3, products (id+1)*15.
    for (int i = 0; i < R; i++) begin
      req_a[i] = N'(i + 1);
      req_b[i] = N'(15);
    end
    clear_logs();
    run_mask(4'b1111, 4);
    chk_q("all4 grant order", glog, 4, 0, 1, 2, 3);
    chk_q("all4 products", rp_log, 4, 15, 30, 45, 60);
    chk_q("all4 ids", rid_log, 4, 0, 1, 2, 3);
    clear_logs();
    run_mask(4'b1001, 2);
    chk_q("rerequest 0,3 order", glog, 2, 0, 3);

    // Single request from 2, cycle by cycle.
    req_a[2] = N'(13);
    req_b[2] = N'(11);
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("single req_ready T", int'(req_ready), 4);
    chk("single rsp_valid T", int'(rsp_valid), 0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("single rsp_valid T+1", int'(rsp_valid), 0);
    chk("single req_ready T+1", int'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single rsp_valid T+2", int'(rsp_valid), 1);
    chk("single rsp_product", int'(rsp_product), 143);
    chk("single rsp_id", int'(rsp_id), 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single back to idle", int'(rsp_valid), 0);
    @(posedge clk); #1;

    // Pointer is now 3: requesters 1 and 3 give 3 then 1, leaving pointer at 2.
    clear_logs();
    run_mask(4'b1010, 2);
    chk_q("wrap grant order", glog, 2, 3, 1);
    chk_q("wrap products", rp_log, 2, 60, 30);
    clear_logs();
    run_mask(4'b0110, 2);
    chk_q("ptr2 grant order", glog, 2, 2, 1);
    chk_q("ptr2 products", rp_log, 2, 143, 30);

    // Backpressure: 15x15 held five cycles with requester 0 waiting.
    rsp_ready = 1'b0;
    req_a[1] = N'(15);
    req_b[1] = N'(15);
    req_valid[1] = 1'b1;
    wait_grant(1);
    req_a[0] = N'(1);
    req_b[0] = N'(1);
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("bp calc rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp rsp_valid", int'(rsp_valid), 1);
      chk("bp rsp_product", int'(rsp_product), 225);
      chk("bp rsp_id", int'(rsp_id), 1);
      chk("bp req_ready", int'(req_ready), 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake valid", int'(rsp_valid), 1);
    chk("bp handshake product", int'(rsp_product), 225);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp after rsp_valid", int'(rsp_valid), 0);
    chk("bp after req_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(p, id);
    chk("bp follow product", p, 1);
    chk("bp follow id", id, 0);

    // Operands change right after accept; result still 7*9.
    req_a[3] = N'(7);
    req_b[3] = N'(9);
    req_valid[3] = 1'b1;
    wait_grant(3);
    req_a[3] = N'(15);
    req_b[3] = N'(15);
    wait_rsp(p, id);
    chk("opchg product", p, 63);
    chk("opchg id", id, 3);

    // Reset during CALC, then grant order restarts at 0.
    req_a[1] = N'(5);
    req_b[1] = N'(5);
    req_valid[1] = 1'b1;
    wait_grant(1);
    chk("pre-reset product", int'(rsp_product), 63);
    chk("pre-reset id", int'(rsp_id), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset rsp_valid", int'(rsp_valid), 0);
    chk("midreset rsp_product", int'(rsp_product), 0);
    chk("midreset rsp_id", int'(rsp_id), 0);
    chk("midreset req_ready", int'(req_ready), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    run_mask(4'b1001, 2);
    chk_q("post-reset grant order", glog, 2, 0, 3);

    // Every 4x4 operand pair through requester 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        req_a[0] = N'(a);
        req_b[0] = N'(b);
        req_valid[0] = 1'b1;
        wait_grant(0);
        wait_rsp(p, id);
        chk("sweep product", p, a * b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Sequential controller that time-shares one `NxN_multiplier` instance between `R` requesters. It arbitrates round-robin among pending requests and latches the winner's operands into the multiplier. It registers the product and returns it on a shared response channel tagged with the requester index. It sits between several client blocks and a single combinational multiplier, so only one multiplier is built.

## Interface
Parameters:
- `N`, 4: operand width in bits; the product is `2*N` bits.
- `R`, 4: number of requesters, ≥2; `IDW = $clog2(R)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  R  per-requester request valid.
- `req_a`  in  R×N  per-requester multiplicand (packed `[R-1:0][N-1:0]`).
- `req_b`  in  R×N  per-requester multiplier (packed `[R-1:0][N-1:0]`).
- `req_ready`  out  R  one-hot grant/accept; 0 or 1 bit set.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_product`  out  2N  registered `a*b`, unsigned.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_product`.

## Operation
- FSM states (`IDLE`, `CALC`, `RESP`):
  - `IDLE`: when any `req_valid` is set, grant the requester (`gnt`).
  - `IDLE` → `CALC` on accept.
  - `CALC` → `RESP` unconditionally.
  - `RESP` → `IDLE` when `rsp_ready`.
- Arbitration is round-robin from pointer `rr_ptr`. `gnt` is the first index `k` in `rr_ptr, rr_ptr+1, … (mod R)` with `req_valid[k]=1`.
- `req_ready[gnt]=1` combinationally, only in `IDLE` and only when some `req_valid` is high. In every other state `req_ready` is all zeros.
- Accept = `req_valid[gnt] && req_ready[gnt]`. On accept:
  - `op_a <= req_a[gnt]`, `op_b <= req_b[gnt]`, `id_q <= gnt`.
  - `rr_ptr <= (gnt+1) mod R`, which wraps from `R-1` to 0.
- In `CALC`, the multiplier sees `op_a`/`op_b`. The product is registered at the end of `CALC`: `prod_q <= product`.
- In `RESP`: `rsp_valid=1`, `rsp_product=prod_q`, `rsp_id=id_q`. All three hold stable until `rsp_ready` is sampled high.
- Arithmetic is unsigned. Full `2N`-bit result, no truncation or overflow.
- Requesters keep `req_valid` asserted until they see their `req_ready`. Deasserting before grant is legal; that requester is simply skipped.
- Operands are captured only at accept. Input changes after accept do not affect the result.

## Timing
- Reset values (asynchronous assert, synchronous-safe release):
  - `state=IDLE`, `rr_ptr=0`
  - `op_a=op_b=0`, `prod_q=0`, `id_q=0`
  - `rsp_valid=0`, `rsp_product=0`, `rsp_id=0`, `req_ready=0`
- Latency: accept in cycle T; `CALC` in T+1; `rsp_valid` high in T+2.
- Throughput: at best one result every 3 cycles, when `rsp_ready` is held high.
- Backpressure: with `rsp_ready=0`, the block stays in `RESP` indefinitely and accepts no new request.
- Simultaneous requests: exactly one is granted per `IDLE` cycle. Losers see `req_ready=0` and keep waiting.
- Same-cycle `RESP` completion and a new request: the block goes to `IDLE` first. The new request can be accepted no earlier than the next cycle, giving 1 idle cycle between responses.
- Reset mid-operation (`CALC` or `RESP`): the transaction is dropped and `rsp_valid` falls immediately. The dropped requester is not notified.

## Structure
- Package `mult_share_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, RESP} ms_state_t;`
  - helper function `rr_pick(valid, ptr)` returning the grant index.
- Sub-module: one instance of the existing `NxN_multiplier #(N)`, port order `(multiplicand, multiplier, product)`, fed from `op_a`/`op_b`.
- All other logic is in `mult_share_arbiter`.

## Test plan
- Single request with N=4, R=4: requester 2 sends a=13, b=11 with `rsp_ready=1`. Expect `req_ready=4'b0100` in cycle T, `rsp_valid` in T+2, `rsp_product=143`, `rsp_id=2`, then `IDLE`.
- All four requesters valid from reset, each with `a=id+1`, `b=15`. Expect grants in order 0,1,2,3 and products 15, 30, 45, 60. Then a re-request from 0 and 3 together with `rr_ptr=0` grants 0 first.
- Wrap-around: with `rr_ptr=3`, requesters 1 and 3 are valid. Expect grant 3, then 1. `rr_ptr` goes 3 → 0 → 2.
- Backpressure: hold `rsp_ready=0` for 5 cycles in `RESP` with 15×15. Expect `rsp_product=225` and `rsp_id` stable, `req_ready=0` throughout, and completion in the cycle `rsp_ready` rises.
- Operand change after accept: change `req_a` the cycle after accept (7×9). The response is still 63.
- Reset mid-`CALC`: assert `rst_n=0` during `CALC`. All outputs go to 0 asynchronously, and after release the next grant starts from requester 0.
- Exhaustive sweep: all 256 a×b pairs through requester 0. Every response matches `a*b` with 4'b×4'b → 8'b.
